// File: rtl/dac_spi_master.sv
// dac_spi_master: SPI master for the DACx0504 serial port.
// Turns one register command into a 24-bit frame (write) or a command frame
// followed by a NOP frame (read), and returns the readback data.
module dac_spi_master #(
    parameter int CLK_DIV = 8,   // SYS_CLK cycles per DAC_CLK period, even, >= 4
    parameter int CS_HOLD = 2,   // cycles from last DAC_CLK fall to DAC_CS_N rise, >= 1
    parameter int CS_GAP  = 4    // minimum cycles DAC_CS_N stays high between frames, >= 1
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        DAC_CLK,
    output logic        DAC_SDI,
    output logic        DAC_CS_N,
    input  logic        DAC_SDO
);

    localparam int HALF       = CLK_DIV / 2;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int PH_W       = 8;
    localparam int FRAME_BITS = 24;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [4:0]   bitCnt_q, bitCnt_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [23:0]  shift_q, shift_d;
    logic [23:0]  cap_q, cap_d;
    logic         rd_q, rd_d;
    logic [3:0]   addr_q, addr_d;
    logic         pend_q, pend_d;
    logic         dacClk_q, dacClk_d;
    logic         csN_q, csN_d;
    logic         cmdReady_q, cmdReady_d;
    logic         rspValid_q, rspValid_d;
    logic [15:0]  rspRdata_q, rspRdata_d;
    logic         rspErr_q, rspErr_d;

    // Every output comes straight from a register so the SPI pins never glitch.
    assign cmd_ready = cmdReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;
    assign DAC_CLK   = dacClk_q;
    assign DAC_SDI   = shift_q[23];
    assign DAC_CS_N  = csN_q;

    // State and datapath registers; reset forces the port into its idle levels.
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q    <= IDLE;
            divCnt_q   <= '0;
            bitCnt_q   <= '0;
            phase_q    <= '0;
            shift_q    <= '0;
            cap_q      <= '0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            pend_q     <= 1'b0;
            dacClk_q   <= 1'b0;
            csN_q      <= 1'b1;
            cmdReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            cap_q      <= cap_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            dacClk_q   <= dacClk_d;
            csN_q      <= csN_d;
            cmdReady_q <= cmdReady_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // Frame sequencer: IDLE -> SHIFT -> HOLD -> GAP -> (NOP frame ? SHIFT : DONE) -> IDLE.
    always_comb begin
        state_d    = state_q;
        divCnt_d   = divCnt_q;
        bitCnt_d   = bitCnt_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        cap_d      = cap_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        dacClk_d   = dacClk_q;
        csN_d      = csN_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmdReady_q) begin
                    rd_d     = cmd_rd;
                    addr_d   = cmd_addr;
                    pend_d   = cmd_rd;
                    shift_d  = {cmd_rd, 3'b000, cmd_addr, (cmd_rd ? 16'h0000 : cmd_wdata)};
                    divCnt_d = '0;
                    bitCnt_d = '0;
                    dacClk_d = 1'b0;
                    csN_d    = 1'b0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                if (divCnt_q == DIV_W'(CLK_DIV - 1)) begin
                    divCnt_d = '0;
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end

                if (divCnt_q == DIV_W'(HALF - 1)) begin
                    // Rising edge: take the SDO bit the DAC presented during the low phase.
                    dacClk_d = 1'b1;
                    cap_d    = {cap_q[22:0], DAC_SDO};
                    bitCnt_d = bitCnt_q + 1'b1;
                end else if (divCnt_q == DIV_W'(CLK_DIV - 1)) begin
                    dacClk_d = 1'b0;
                    if (bitCnt_q == 5'(FRAME_BITS)) begin
                        phase_d = '0;
                        state_d = HOLD;
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end
            end

            HOLD: begin
                if (phase_q == PH_W'(CS_HOLD - 1)) begin
                    csN_d   = 1'b1;
                    shift_d = '0;
                    phase_d = '0;
                    state_d = GAP;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            GAP: begin
                if (phase_q == PH_W'(CS_GAP - 1)) begin
                    if (pend_q) begin
                        // Second frame of a read is an all-zero NOP that clocks the data back.
                        pend_d   = 1'b0;
                        shift_d  = '0;
                        divCnt_d = '0;
                        bitCnt_d = '0;
                        csN_d    = 1'b0;
                        state_d  = SHIFT;
                    end else begin
                        rspValid_d = 1'b1;
                        rspRdata_d = rd_q ? cap_q[15:0] : 16'h0000;
                        rspErr_d   = rd_q & ((cap_q[19:16] != addr_q) | ~cap_q[23]);
                        state_d    = DONE;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cmdReady_d = (state_d == IDLE);
    end

endmodule
